// File: rtl/wfa_pkg.sv
// rtl/wfa_pkg.sv - W-beat field layout and arbiter state encoding shared by the W forward arbiter.
package wfa_pkg;

  localparam int W_BEAT_W   = 77;
  localparam int W_LAST_BIT = 0;
  localparam int W_ADDR_LSB = 33;
  localparam int W_ADDR_MSB = 68;

  typedef enum logic {
    WFA_IDLE,
    WFA_LOCKED
  } wfa_state_e;

endpackage

// File: rtl/w_forward_arbiter_rr_pick.sv
// rtl/w_forward_arbiter_rr_pick.sv - combinational round-robin one-hot picker (first requester at or after ptr).
module rr_pick #(
  parameter  int NUM_SRC = 4,
  localparam int PW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_SRC-1:0] grant
);

  logic          found;
  int            j;
  logic [PW-1:0] jx;

  // Scan NUM_SRC slots starting at ptr; the wrap is an explicit compare so
  // non-power-of-two source counts rotate correctly.
  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = 0;
    jx    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_SRC) begin
        j = j - NUM_SRC;
      end
      jx = PW'(j);
      if (!found && req[jx]) begin
        grant[jx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/w_forward_arbiter.sv
// rtl/w_forward_arbiter.sv - burst-locked round-robin W-path arbiter; optional stall watchdog under WFA_WATCHDOG_EN.
module w_forward_arbiter
  import wfa_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_SRC*W_BEAT_W-1:0]   DATAi,
  input  logic [NUM_SRC-1:0]            VALIDi,
  output logic [NUM_SRC-1:0]            READYi,
  output logic [W_BEAT_W-1:0]           DATAo,
  output logic                          VALIDo,
  input  logic                          READYo,
  output logic [NUM_SRC-1:0]            GRANT,
  output logic                          BUSY,
  output logic                          WDOG_ERR
);

  localparam int PW = $clog2(NUM_SRC);

  wfa_state_e            state;
  logic [NUM_SRC-1:0]    grant_q;
  logic [NUM_SRC-1:0]    pick;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         gidx;
  logic [PW-1:0]         pick_idx;
  logic [W_BEAT_W-1:0]   data_mux;
  logic                  valid_mux;
  logic                  fire;
  logic                  last_fire;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req   (VALIDi),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pick[k]) begin
        pick_idx = PW'(k);
      end
    end
  end

  // AND-OR mux over the one-hot grant; an all-zero grant yields zero data and no valid.
  always_comb begin
    data_mux  = '0;
    valid_mux = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      data_mux  = data_mux | ({W_BEAT_W{grant_q[k]}} & DATAi[k*W_BEAT_W +: W_BEAT_W]);
      valid_mux = valid_mux | (grant_q[k] & VALIDi[k]);
    end
  end

  assign DATAo     = data_mux;
  assign VALIDo    = valid_mux;
  assign READYi    = grant_q & {NUM_SRC{READYo}};
  assign GRANT     = grant_q;
  assign BUSY      = (state == WFA_LOCKED);
  assign fire      = valid_mux & READYo;
  assign last_fire = fire & data_mux[W_LAST_BIT];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= WFA_IDLE;
      grant_q <= '0;
      gidx    <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        WFA_IDLE: begin
          if (|VALIDi) begin
            state   <= WFA_LOCKED;
            grant_q <= pick;
            gidx    <= pick_idx;
          end
        end
        WFA_LOCKED: begin
          if (last_fire) begin
            state   <= WFA_IDLE;
            grant_q <= '0;
            rr_ptr  <= (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + PW'(1);
          end
        end
        default: state <= WFA_IDLE;
      endcase
    end
  end

`ifdef WFA_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_nxt;
  logic          wdog_q;

  // Counts locked cycles without a presented beat; the grant is never forced off.
  always_comb begin
    stall_nxt = '0;
    if (state == WFA_LOCKED) begin
      if (fire) begin
        stall_nxt = '0;
      end else if (!valid_mux && (stall_cnt != CW'(WDOG_CYCLES))) begin
        stall_nxt = stall_cnt + CW'(1);
      end else begin
        stall_nxt = stall_cnt;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt <= '0;
      wdog_q    <= 1'b0;
    end else begin
      stall_cnt <= stall_nxt;
      if (stall_nxt == CW'(WDOG_CYCLES)) begin
        wdog_q <= 1'b1;
      end
    end
  end

  assign WDOG_ERR = wdog_q;
`else
  assign WDOG_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_w_forward_arbiter.sv
// tb/tb_w_forward_arbiter.sv - scoreboard bench for w_forward_arbiter (NUM_SRC=4, WDOG_CYCLES=8).
module tb_w_forward_arbiter;

  localparam int NS = 4;
  localparam int BW = 77;
`ifdef WFA_WATCHDOG_EN
  localparam bit WDOG_EXP = 1'b1;
`else
  localparam bit WDOG_EXP = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RESET;
  logic [NS*BW-1:0] DATAi;
  logic [NS-1:0]   VALIDi;
  logic [NS-1:0]   READYi;
  logic [BW-1:0]   DATAo;
  logic            VALIDo;
  logic            READYo;
  logic [NS-1:0]   GRANT;
  logic            BUSY;
  logic            WDOG_ERR;

  w_forward_arbiter #(.NUM_SRC(NS), .WDOG_CYCLES(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .DATAi    (DATAi),
    .VALIDi   (VALIDi),
    .READYi   (READYi),
    .DATAo    (DATAo),
    .VALIDo   (VALIDo),
    .READYo   (READYo),
    .GRANT    (GRANT),
    .BUSY     (BUSY),
    .WDOG_ERR (WDOG_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [BW-1:0] data;
    logic [NS-1:0] grant;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] src_q[NS][$];
  logic [NS-1:0] hold = '0;
  int            rdy_mode = 0;
  bit            check_gap = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_data = '0;
  int            gap = 0;
  bit            after_last = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] mk_beat(input int src, input int idx, input bit last);
    logic [BW-1:0] b;
    logic [3:0]    s;
    logic [7:0]    i8;
    s  = src[3:0];
    i8 = idx[7:0];
    b         = '0;
    b[76:69]  = i8 ^ 8'hA5;
    b[68:33]  = {s, i8, 24'h5A3C96};
    b[32:1]   = 32'(src * 7919 + idx);
    b[0]      = last;
    return b;
  endfunction

  // Queue a burst on a source and its expected output beats, in expected grant order.
  task automatic add_burst(input int src, input int nbeats, input int tag);
    logic [BW-1:0] b;
    exp_t          e;
    for (int i = 0; i < nbeats; i++) begin
      b = mk_beat(src, tag + i, (i == nbeats - 1));
      src_q[src].push_back(b);
      e.data  = b;
      e.grant = NS'(1 << src);
      exp_q.push_back(e);
    end
  endtask

  task automatic flush_all();
    exp_q.delete();
    for (int k = 0; k < NS; k++) src_q[k].delete();
    hold     = '0;
    rdy_mode = 0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge CLK);
      t++;
    end
    chk(name, 128'(exp_q.size()), 128'd0);
    if (exp_q.size() != 0) flush_all();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    flush_all();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin : driver
    logic [NS-1:0] fire;
    VALIDi = '0;
    DATAi  = '0;
    READYo = 1'b1;
    forever begin
      @(negedge CLK);
      fire = VALIDi & READYi;
      @(posedge CLK);
      #1;
      for (int k = 0; k < NS; k++) begin
        if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0 && !hold[k]) begin
          VALIDi[k]          = 1'b1;
          DATAi[k*BW +: BW]  = src_q[k][0];
        end else begin
          VALIDi[k]          = 1'b0;
          DATAi[k*BW +: BW]  = '0;
        end
      end
      case (rdy_mode)
        1:       READYo = ~READYo;
        2:       READYo = 1'b0;
        default: READYo = 1'b1;
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        prev_stall = 1'b0;
        after_last = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("stall_valid_held", 128'(VALIDo), 128'd1);
        chk("stall_data_stable", 128'(DATAo), 128'(prev_data));
      end
      if (VALIDo && READYo) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h required no beat", DATAo);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 128'(DATAo), 128'(e.data));
          chk("beat_grant", 128'(GRANT), 128'(e.grant));
          chk("beat_ready", 128'(READYi), 128'(e.grant));
        end
        if (check_gap && after_last) chk("burst_gap", 128'(gap), 128'd1);
        after_last = DATAo[0];
        gap        = 0;
      end else if (after_last) begin
        gap++;
      end
      if (!check_gap) after_last = 1'b0;
      prev_stall = VALIDo && !READYo;
      prev_data  = DATAo;
    end
  end

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    // 1: idle with no requests
    repeat (20) begin
      @(negedge CLK);
      chk("idle_outputs", 128'({GRANT, VALIDo, READYi, BUSY, WDOG_ERR, DATAo}), 128'd0);
    end

    // 2: single 4-beat burst on src1, then rr_ptr=2 observed via src2 beating src0
    add_burst(1, 4, 8'h10);
    t = 0;
    @(negedge CLK);
    while (!VALIDi[1] && t < 10) begin
      @(negedge CLK);
      t++;
    end
    chk("t2_bubble_grant", 128'(GRANT), 128'd0);
    @(negedge CLK);
    chk("t2_grant", 128'(GRANT), 128'b0010);
    chk("t2_busy", 128'(BUSY), 128'd1);
    wait_drain("t2_drain");
    @(negedge CLK);
    chk("t2_release", 128'({GRANT, BUSY}), 128'd0);
    add_burst(2, 1, 8'h20);
    add_burst(0, 1, 8'h30);
    wait_drain("t2_rr_drain");

    // 3: all four request from rr_ptr=0 -> 0,1,2,3,0 with one bubble between bursts
    do_reset();
    check_gap = 1'b1;
    add_burst(0, 2, 8'h00);
    add_burst(1, 2, 8'h00);
    add_burst(2, 2, 8'h00);
    add_burst(3, 2, 8'h00);
    add_burst(0, 2, 8'h02);
    wait_drain("t3_drain");
    @(negedge CLK);
    check_gap = 1'b0;

    // 4: src2 with toggling READYo, then a WLAST beat stalled by READYo=0
    rdy_mode = 1;
    add_burst(2, 8, 8'h40);
    wait_drain("t4_drain");
    @(negedge CLK);
    rdy_mode = 2;
    add_burst(1, 1, 8'h50);
    t = 0;
    while (!BUSY && t < 10) begin
      @(negedge CLK);
      t++;
    end
    chk("t4_lock_busy", 128'(BUSY), 128'd1);
    repeat (3) begin
      @(negedge CLK);
      chk("t4_wlast_hold", 128'({GRANT, VALIDo, READYi}), 128'({4'b0010, 1'b1, 4'b0000}));
    end
    rdy_mode = 0;
    wait_drain("t4_wlast_drain");

    // 5: reset during beat 2 of an 8-beat burst; rr_ptr must return to 0
    @(negedge CLK);
    add_burst(2, 8, 8'h60);
    t = 0;
    while (exp_q.size() > 7 && t < 20) begin
      @(posedge CLK);
      t++;
    end
    @(negedge CLK);
    RESET = 1'b1;
    flush_all();
    @(negedge CLK);
    chk("t5_reset_outputs", 128'({GRANT, VALIDo, BUSY, READYi}), 128'd0);
    RESET = 1'b0;
    add_burst(0, 1, 8'h70);
    add_burst(3, 1, 8'h78);
    wait_drain("t5_drain");

    // 6: granted source stalls 8 cycles mid-burst
    @(negedge CLK);
    add_burst(1, 4, 8'h80);
    t = 0;
    while (exp_q.size() > 3 && t < 20) begin
      @(posedge CLK);
      t++;
    end
    hold[1] = 1'b1;
    repeat (8) @(negedge CLK);
    chk("t6_err_before", 128'(WDOG_ERR), 128'd0);
    chk("t6_grant_held", 128'({GRANT, BUSY, VALIDo}), 128'({4'b0010, 1'b1, 1'b0}));
    hold[1] = 1'b0;
    @(negedge CLK);
    chk("t6_err_rise", 128'(WDOG_ERR), 128'(WDOG_EXP));
    chk("t6_grant_kept", 128'(GRANT), 128'b0010);
    wait_drain("t6_drain");
    @(negedge CLK);
    chk("t6_err_sticky", 128'({BUSY, WDOG_ERR}), 128'({1'b0, WDOG_EXP}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
